lsu_arbiter: RTL
================

Name: lsu_arbiter

Overview:
- Parametrised load/store arbiter for the Tomasulo memory path.
- Sits between the load/store reservation stations and a single-port synchronous data memory.
- Grants one access per cycle, using round-robin within the load class and within the store class, and a selectable priority between classes.
- Holds each load result in an output register until the CDB accepts it (tag match), so no result is lost.

Parameters:
- NUM_LOAD, 2, number of load slots (>=1)
- NUM_STORE, 2, number of store slots (>=1)
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TAG_W, 4, reservation-station tag width
- LOAD_FIRST, 1, 1: loads beat stores; 0: stores beat loads

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous active-high reset
- load_valid  in  NUM_LOAD  load slot i requests access
- load_addr  in  NUM_LOAD*ADDR_W  slot i address at bits [i*ADDR_W +: ADDR_W]
- load_tag  in  NUM_LOAD*TAG_W  slot i tag
- load_grant  out  NUM_LOAD  one-hot, slot i accepted this cycle
- store_valid  in  NUM_STORE  store slot j requests access
- store_addr  in  NUM_STORE*ADDR_W  slot j address
- store_data  in  NUM_STORE*DATA_W  slot j write data
- store_grant  out  NUM_STORE  one-hot, slot j written this cycle
- cdb_valid  in  1  CDB broadcast valid
- cdb_tag  in  TAG_W  CDB broadcast tag
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid one cycle after address
- result_valid  out  1  load result pending for CDB
- result_tag  out  TAG_W  tag of pending result
- result_data  out  DATA_W  pending load data

Behaviour:
- Handshake: a slot holds valid/addr/tag/data stable until its grant. A grant is combinational in the same cycle, and the slot drops or changes its request the following cycle. Grants are never issued to slots whose valid is low.
- At most one bit across load_grant|store_grant is set per cycle.
- Load eligibility: load_ok = !result_valid || (cdb_valid && cdb_tag==result_tag). The result register frees in the same cycle the CDB accepts it.
- Selection when LOAD_FIRST=1:
  - If any load_valid and load_ok: grant a load.
  - Else if any store_valid: grant a store.
  - Else: idle.
- Selection when LOAD_FIRST=0: stores are granted first, then loads (loads still subject to load_ok).
- Blocked loads: when load_ok is low, stores may still proceed whatever LOAD_FIRST is set to.
- Round-robin: each class has a pointer (width clog2, min 1 bit). Search starts at the pointer and wraps modulo NUM_x. After a grant to index k, the pointer becomes (k+1) mod NUM_x. The pointer is unchanged when its class is not granted.
- Memory drive, load granted in cycle T:
  - mem_we=0, mem_addr=load addr.
  - Tag captured at the T edge.
  - At T+1: result_valid=1, result_tag=captured tag, result_data=mem_rdata. result_data is registered from mem_rdata at the end of T+1 and held stable thereafter.
- Memory drive, store granted: mem_we=1, mem_addr/mem_wdata = slot values in the same cycle. Write completes at that edge.
- Memory drive, idle: mem_we=0. mem_addr/mem_wdata hold their last values (no X propagation).
- Result clear: a CDB tag match clears result_valid at the next edge, unless a new load was granted that cycle, in which case the new result replaces it at T+1.
- A CDB broadcast with a non-matching tag has no effect.
- Reset (also mid-operation): load_grant=0, store_grant=0, mem_we=0, mem_addr=0, mem_wdata=0, result_valid=0, result_tag=0, result_data=0, both pointers=0. Any in-flight load is dropped.
- Latency: load grant to result_valid = 1 cycle. Store grant to write = 0 cycles (same edge).

Test Plan:
- Reset, then load0 valid, addr 0x10, tag 3, mem word 0x10=0xAB -> load_grant=01 at T; result_valid=1, tag 3, data 0xAB at T+1; cdb 3 at T+2 -> result_valid=0 at T+3.
- load0 and load1 both valid continuously with immediate CDB acks -> grants alternate 01,10,01,10. With a 1-slot NUM_LOAD=1 build, the same slot is regranted every cycle.
- Result pending (tag 5), CDB silent, load1 valid plus store0 valid (addr 0x20, data 0x55) -> store_grant=01, mem_we=1, load_grant=0, until cdb_tag=5.
- Result tag 5 pending, cdb_valid=1 with cdb_tag=5 and load0 valid (tag 7) in the same cycle -> load_grant=01 that cycle; next cycle result_tag=7, result_valid=1.
- LOAD_FIRST=0, load0 and store1 valid together -> store_grant=10 first, load_grant=01 next cycle. CDB tag 9 while result tag 2 pending -> no clear.
- Reset asserted the cycle after a load grant -> result_valid stays 0, pointers return to 0, mem_we=0.

Source files
------------

// File: rtl/lsu_arbiter.sv
// Load/store arbiter between the reservation stations and a single-port synchronous data memory.
// Round-robin within each class, selectable class priority, and a held load-result register for the CDB.
module lsu_arbiter #(
  parameter int NUM_LOAD   = 2,
  parameter int NUM_STORE  = 2,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int TAG_W      = 4,
  parameter int LOAD_FIRST = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_LOAD-1:0]         load_valid,
  input  logic [NUM_LOAD*ADDR_W-1:0]  load_addr,
  input  logic [NUM_LOAD*TAG_W-1:0]   load_tag,
  output logic [NUM_LOAD-1:0]         load_grant,
  input  logic [NUM_STORE-1:0]        store_valid,
  input  logic [NUM_STORE*ADDR_W-1:0] store_addr,
  input  logic [NUM_STORE*DATA_W-1:0] store_data,
  output logic [NUM_STORE-1:0]        store_grant,
  input  logic                        cdb_valid,
  input  logic [TAG_W-1:0]            cdb_tag,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic                        result_valid,
  output logic [TAG_W-1:0]            result_tag,
  output logic [DATA_W-1:0]           result_data
);

  localparam int LP_W = (NUM_LOAD > 1) ? $clog2(NUM_LOAD) : 1;
  localparam int SP_W = (NUM_STORE > 1) ? $clog2(NUM_STORE) : 1;

  // Handshake: a slot holds valid and its fields stable until its grant bit is
  // seen high in the same cycle; it drops or changes the request the next cycle.
  // Grants are combinational and only ever go to slots whose valid is high.

  function automatic int wrap(input int v, input int n);
    return (v >= n) ? v - n : v;
  endfunction

  logic [LP_W-1:0]     load_ptr;
  logic [SP_W-1:0]     store_ptr;
  logic [NUM_LOAD-1:0] load_sel;
  logic [NUM_STORE-1:0] store_sel;
  logic [LP_W-1:0]     load_idx;
  logic [SP_W-1:0]     store_idx;
  logic                load_found;
  logic                store_found;
  logic                load_ok;
  logic                ld_req;
  logic                st_req;
  logic                pick_load;
  logic                pick_store;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   data_q;
  logic                rd_pending;
  logic [ADDR_W-1:0]   sel_load_addr;
  logic [TAG_W-1:0]    sel_load_tag;
  logic [ADDR_W-1:0]   sel_store_addr;
  logic [DATA_W-1:0]   sel_store_data;

  // Round-robin search for loads, starting at the pointer and wrapping.
  always_comb begin
    load_sel   = '0;
    load_idx   = '0;
    load_found = 1'b0;
    for (int off = 0; off < NUM_LOAD; off++) begin
      if (!load_found && load_valid[wrap(int'(load_ptr) + off, NUM_LOAD)]) begin
        load_found = 1'b1;
        load_sel[wrap(int'(load_ptr) + off, NUM_LOAD)] = 1'b1;
        load_idx = LP_W'(wrap(int'(load_ptr) + off, NUM_LOAD));
      end
    end
  end

  always_comb begin
    store_sel   = '0;
    store_idx   = '0;
    store_found = 1'b0;
    for (int off = 0; off < NUM_STORE; off++) begin
      if (!store_found && store_valid[wrap(int'(store_ptr) + off, NUM_STORE)]) begin
        store_found = 1'b1;
        store_sel[wrap(int'(store_ptr) + off, NUM_STORE)] = 1'b1;
        store_idx = SP_W'(wrap(int'(store_ptr) + off, NUM_STORE));
      end
    end
  end

  assign sel_load_addr  = load_addr[int'(load_idx)*ADDR_W +: ADDR_W];
  assign sel_load_tag   = load_tag[int'(load_idx)*TAG_W +: TAG_W];
  assign sel_store_addr = store_addr[int'(store_idx)*ADDR_W +: ADDR_W];
  assign sel_store_data = store_data[int'(store_idx)*DATA_W +: DATA_W];

  // The result register frees in the very cycle the CDB takes it.
  assign load_ok = !result_valid || (cdb_valid && (cdb_tag == result_tag));
  assign ld_req  = !reset && load_found && load_ok;
  assign st_req  = !reset && store_found;

  always_comb begin
    if (LOAD_FIRST != 0) begin
      pick_load  = ld_req;
      pick_store = st_req && !ld_req;
    end else begin
      pick_store = st_req;
      pick_load  = ld_req && !st_req;
    end
  end

  assign load_grant  = pick_load  ? load_sel  : '0;
  assign store_grant = pick_store ? store_sel : '0;

  // Idle cycles replay the last address/data so the memory never sees X.
  assign mem_we    = pick_store;
  assign mem_addr  = pick_load ? sel_load_addr : (pick_store ? sel_store_addr : addr_q);
  assign mem_wdata = pick_store ? sel_store_data : wdata_q;

  // Read data is live from the memory in the first result cycle, then held.
  assign result_data = rd_pending ? mem_rdata : data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      load_ptr     <= '0;
      store_ptr    <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      data_q       <= '0;
      rd_pending   <= 1'b0;
      result_valid <= 1'b0;
      result_tag   <= '0;
    end else begin
      addr_q     <= mem_addr;
      wdata_q    <= mem_wdata;
      rd_pending <= pick_load;
      if (rd_pending) data_q <= mem_rdata;
      if (pick_load) begin
        load_ptr     <= LP_W'(wrap(int'(load_idx) + 1, NUM_LOAD));
        result_valid <= 1'b1;
        result_tag   <= sel_load_tag;
      end else if (result_valid && cdb_valid && (cdb_tag == result_tag)) begin
        result_valid <= 1'b0;
      end
      if (pick_store) store_ptr <= SP_W'(wrap(int'(store_idx) + 1, NUM_STORE));
    end
  end

endmodule
